mips_multicycle_ctrl: RTL

Multicycle MIPS control state machine that sequences every instruction through fetch, decode, execute, memory and write-back, and drives all datapath enables and mux selects. It sits directly upstream of the 8:1 32-bit write-back mux, supplying its 3-bit `mem_to_reg` select. It also handles a ready/wait handshake with the unified memory.

---
 rtl/mips_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM driving datapath enables and mux selects
//
// Sequences each instruction through fetch, decode, execute, memory and write-back.
// It waits on the unified memory through a mem_ready handshake.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   opcode     in   IR[31:26], stable from DECODE until the return to FETCH
//   funct      in   IR[5:0], same stability rule
//   zero       in   ALU zero flag, sampled only in BRANCH
//   mem_ready  in   memory finished the current access this cycle
//   pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, alu_src_a  out  datapath controls
//   reg_dst    out  00 rt, 01 rd, 10 $31
//   mem_to_reg out  000 ALUOut, 001 MDR, 010 PC, 011 imm<<16
//   alu_src_b  out  00 B, 01 4, 10 sext imm, 11 sext imm<<2
//   alu_op     out  00 add, 01 sub, 10 funct, 11 imm-op
//   pc_source  out  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector
//   state      out  current state (debug)
//   illegal    out  one-cycle pulse on trap
//
// Build option: define ILLEGAL_TRAP_EN so an undefined opcode redirects the PC to
// the exception vector. When it is undefined, TRAP is a one-cycle NOP.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] reg_dst,
    output logic [2:0] mem_to_reg,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_LUI_WB    = 4'd12,
        S_JR        = 4'd13,
        S_JAL       = 4'd14,
        S_TRAP      = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    state_t r_state;
    state_t w_next;
    state_t w_dispatch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

    assign state = r_state;

    always_comb begin
        w_dispatch = S_TRAP;
        case (opcode)
            OP_LW, OP_SW:                      w_dispatch = S_MEM_ADDR;
            OP_RTYPE:                          w_dispatch = (funct == FN_JR) ? S_JR : S_R_EXEC;
            OP_BEQ, OP_BNE:                    w_dispatch = S_BRANCH;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_dispatch = S_I_EXEC;
            OP_LUI:                            w_dispatch = S_LUI_WB;
            OP_J:                              w_dispatch = S_JUMP;
            OP_JAL:                            w_dispatch = S_JAL;
            default:                           w_dispatch = S_TRAP;
        endcase
    end

    always_comb begin
        w_next     = S_FETCH;
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 3'b000;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // Gated by reset_n so nothing is latched while reset is held.
                ir_write  = mem_ready & reset_n;
                pc_write  = mem_ready & reset_n;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                w_next    = w_dispatch;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                w_next   = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 3'b001;
            end
            S_MEM_WRITE: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                w_next    = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                // bne inverts the sense of the zero flag.
                pc_write  = zero ^ (opcode == OP_BNE);
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                w_next    = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
            end
            S_LUI_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 3'b011;
            end
            S_JR: begin
                pc_write  = 1'b1;
                alu_src_a = 1'b1;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 3'b010;
            end
            S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                pc_write  = 1'b1;
                pc_source = 2'b11;
                illegal   = 1'b1;
`endif
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule
